multicycle_controller: RTL and testbench

Main control unit for the multicycle MIPS datapath. A Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback, driving the datapath mux selects, write enables and the 2-bit `ALUop` consumed by the ALU control decoder. It sits between the instruction register opcode field and the datapath, and uses a `mem_ready` handshake to stall on a slow shared instruction/data memory.

---
 rtl/mips_ctrl_pkg.sv | 64 ++++++
 rtl/ctrl_output_decode.sv | 88 ++++++++
 rtl/multicycle_controller.sv | 88 ++++++++
 tb/tb_multicycle_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, state
// encoding, datapath select codes and the control output bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    ADDIEX = 4'd8,
    ADDIWB = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11
  } ctrl_state_e;

  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_out_t;

  function automatic logic is_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: is_supported = 1'b1;
      default:                                               is_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational Moore-style output decode for the multicycle controller;
// only mem_ready, zero and opcode qualify individual strobes.
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  ctrl_state_e state_i,
  input  logic [5:0]  opcode_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output ctrl_out_t   ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.iord      = 1'b0;
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_en     = mem_ready_i;
      end
      DECODE: begin
        // Branch target is computed speculatively here into ALUOut.
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALUOP_ADD;
        if (!is_supported(opcode_i)) begin
          ctrl_o.illegal_op = 1'b1;
          ctrl_o.instr_done = 1'b1;
        end
      end
      MEMADR, ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl_o.iord = 1'b1;
      end
      MEMWB: begin
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      MEMWR: begin
        ctrl_o.iord       = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REGB;
        ctrl_o.alu_op    = ALUOP_RTYPE;
      end
      ALUWB: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.mem_to_reg = 1'b0;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ADDIWB: begin
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.mem_to_reg = 1'b0;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = SRCB_REGB;
        ctrl_o.alu_op     = ALUOP_SUB;
        ctrl_o.pc_src     = PCSRC_ALUOUT;
        ctrl_o.pc_en      = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
        ctrl_o.instr_done = 1'b1;
      end
      JUMP: begin
        ctrl_o.pc_src     = PCSRC_JUMP;
        ctrl_o.pc_en      = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS main control FSM: state register and next-state logic here,
// output decode in ctrl_output_decode, all outputs held at 0 during reset.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSrc,
  output logic       instr_done,
  output logic       illegal_op
);

  ctrl_state_e state_q, state_d;
  ctrl_out_t   dec_out;
  ctrl_out_t   ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   state_d = MEMADR;
          OP_RTYPE:       state_d = EXEC;
          OP_ADDI:        state_d = ADDIEX;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J:           state_d = JUMP;
          default:        state_d = FETCH;
        endcase
      end
      MEMADR: state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (mem_ready) state_d = FETCH;
      EXEC:   state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      ADDIEX: state_d = ADDIWB;
      ADDIWB: state_d = FETCH;
      BRANCH: state_d = FETCH;
      JUMP:   state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  ctrl_output_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .ctrl_o      (dec_out)
  );

  // Reset gates the decode directly so no strobe can leak while it is held.
  assign ctrl = reset ? '0 : dec_out;

  assign PCEn       = ctrl.pc_en;
  assign IorD       = ctrl.iord;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign RegDst     = ctrl.reg_dst;
  assign MemtoReg   = ctrl.mem_to_reg;
  assign RegWrite   = ctrl.reg_write;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ALUop      = ctrl.alu_op;
  assign PCSrc      = ctrl.pc_src;
  assign instr_done = ctrl.instr_done;
  assign illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: expected output vectors are queued
// as each cycle's stimulus is applied and compared mid-cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUop, PCSrc;
  logic       instr_done, illegal_op;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];
  logic [15:0] obs;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCEn       (PCEn),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUop      (ALUop),
    .PCSrc      (PCSrc),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  assign obs = {PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUop, PCSrc, instr_done, illegal_op};

  function automatic logic [15:0] mk(input logic pcen, iord, mw, irw, rd, m2r, rw, srca,
                                     input logic [1:0] srcb, aluop, pcsrc,
                                     input logic done, ill);
    return {pcen, iord, mw, irw, rd, m2r, rw, srca, srcb, aluop, pcsrc, done, ill};
  endfunction

  // Expected output vectors, one per state / input qualification
  logic [15:0] E_ZERO, E_FETCH_R, E_FETCH_W, E_DEC, E_DEC_ILL, E_MEMADR, E_MEMRD,
               E_MEMWB, E_MEMWR_W, E_MEMWR_R, E_EXEC, E_ALUWB, E_ADDIEX, E_ADDIWB,
               E_BR_TAKEN, E_BR_NOT, E_JUMP;

  task automatic cyc(input string tag, input logic [15:0] e);
    logic [15:0] want;
    string       t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, obs, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    E_ZERO     = '0;
    E_FETCH_R  = mk(1,0,0,1,0,0,0,0,2'b01,2'b10,2'b00,0,0);
    E_FETCH_W  = mk(0,0,0,0,0,0,0,0,2'b01,2'b10,2'b00,0,0);
    E_DEC      = mk(0,0,0,0,0,0,0,0,2'b11,2'b10,2'b00,0,0);
    E_DEC_ILL  = mk(0,0,0,0,0,0,0,0,2'b11,2'b10,2'b00,1,1);
    E_MEMADR   = mk(0,0,0,0,0,0,0,1,2'b10,2'b10,2'b00,0,0);
    E_MEMRD    = mk(0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    E_MEMWB    = mk(0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0);
    E_MEMWR_W  = mk(0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    E_MEMWR_R  = mk(0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,1,0);
    E_EXEC     = mk(0,0,0,0,0,0,0,1,2'b00,2'b00,2'b00,0,0);
    E_ALUWB    = mk(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0);
    E_ADDIEX   = mk(0,0,0,0,0,0,0,1,2'b10,2'b10,2'b00,0,0);
    E_ADDIWB   = mk(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0);
    E_BR_TAKEN = mk(1,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
    E_BR_NOT   = mk(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
    E_JUMP     = mk(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0);

    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 6'b100011;
    cyc("reset_hold_ready", E_ZERO);
    cyc("reset_hold_ready2", E_ZERO);
    reset = 1'b0;

    // lw, memory always ready: 5 cycles
    cyc("lw_fetch", E_FETCH_R);
    cyc("lw_decode", E_DEC);
    cyc("lw_memadr", E_MEMADR);
    cyc("lw_memrd", E_MEMRD);
    cyc("lw_memwb", E_MEMWB);

    // sw with three wait cycles in MEMWR: 7 cycles
    opcode = 6'b101011;
    cyc("sw_fetch", E_FETCH_R);
    cyc("sw_decode", E_DEC);
    cyc("sw_memadr", E_MEMADR);
    mem_ready = 1'b0;
    cyc("sw_memwr_wait1", E_MEMWR_W);
    cyc("sw_memwr_wait2", E_MEMWR_W);
    cyc("sw_memwr_wait3", E_MEMWR_W);
    mem_ready = 1'b1;
    cyc("sw_memwr_done", E_MEMWR_R);

    // beq taken, with one fetch stall first
    opcode = 6'b000100; zero = 1'b1; mem_ready = 1'b0;
    cyc("beq_fetch_stall", E_FETCH_W);
    mem_ready = 1'b1;
    cyc("beq_fetch", E_FETCH_R);
    cyc("beq_decode", E_DEC);
    cyc("beq_branch_taken", E_BR_TAKEN);

    // bne with zero=1 does not redirect the PC
    opcode = 6'b000101;
    cyc("bne_fetch", E_FETCH_R);
    cyc("bne_decode", E_DEC);
    cyc("bne_branch_not", E_BR_NOT);

    // bne with zero=0 is taken
    zero = 1'b0;
    cyc("bne2_fetch", E_FETCH_R);
    cyc("bne2_decode", E_DEC);
    cyc("bne2_branch_taken", E_BR_TAKEN);

    // R-type then addi back to back: 8 cycles
    opcode = 6'b000000;
    cyc("r_fetch", E_FETCH_R);
    cyc("r_decode", E_DEC);
    cyc("r_exec", E_EXEC);
    cyc("r_aluwb", E_ALUWB);
    opcode = 6'b001000;
    cyc("addi_fetch", E_FETCH_R);
    cyc("addi_decode", E_DEC);
    cyc("addi_ex", E_ADDIEX);
    cyc("addi_wb", E_ADDIWB);

    // jump
    opcode = 6'b000010;
    cyc("j_fetch", E_FETCH_R);
    cyc("j_decode", E_DEC);
    cyc("j_jump", E_JUMP);

    // illegal opcode: 2 cycles, then the next fetch
    opcode = 6'b111111;
    cyc("ill_fetch", E_FETCH_R);
    cyc("ill_decode", E_DEC_ILL);
    mem_ready = 1'b0;
    cyc("ill_next_fetch", E_FETCH_W);
    mem_ready = 1'b1;

    // another illegal opcode
    opcode = 6'b010000;
    cyc("ill2_fetch", E_FETCH_R);
    cyc("ill2_decode", E_DEC_ILL);

    // lw with one wait cycle in MEMRD
    opcode = 6'b100011;
    cyc("lw2_fetch", E_FETCH_R);
    cyc("lw2_decode", E_DEC);
    cyc("lw2_memadr", E_MEMADR);
    mem_ready = 1'b0;
    cyc("lw2_memrd_wait", E_MEMRD);
    mem_ready = 1'b1;
    cyc("lw2_memrd", E_MEMRD);
    cyc("lw2_memwb", E_MEMWB);

    // reset asserted mid-MEMWR abandons the store
    opcode = 6'b101011;
    cyc("swr_fetch", E_FETCH_R);
    cyc("swr_decode", E_DEC);
    cyc("swr_memadr", E_MEMADR);
    mem_ready = 1'b0;
    cyc("swr_memwr_wait", E_MEMWR_W);
    reset = 1'b1;
    cyc("swr_reset_low_ready", E_ZERO);
    mem_ready = 1'b1;
    cyc("swr_reset_high_ready", E_ZERO);
    mem_ready = 1'b0;
    reset = 1'b0;
    cyc("swr_after_reset_fetch", E_FETCH_W);
    mem_ready = 1'b1;
    cyc("swr_after_reset_fetch_rdy", E_FETCH_R);
    opcode = 6'b000010;
    cyc("post_reset_j_decode", E_DEC);
    cyc("post_reset_j_jump", E_JUMP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
